// File: rtl/ir_program_sequencer.sv
// ir_program_sequencer: plays a small instruction buffer into the SPARC IR.
// Each stored word gives a one-cycle IR_Enable pulse, followed by GAP_CYCLES idle
// cycles. The gap can be stretched with hold, and abort stops playback.
// The number of words played is prog_len, clamped to DEPTH. issued counts load
// pulses and saturates at its maximum.
// All outputs are registered from the next-state decode, so IR_Enable is high
// exactly while the FSM sits in LOAD.
// Optional feature macro: SEQ_LOOP_EN. When it is defined and start is still
// high as the last word's gap expires, playback wraps back to entry 0.
module ir_program_sequencer #(
    parameter int IR_W       = 32,
    parameter int DEPTH      = 16,
    parameter int AW         = 4,
    parameter int GAP_CYCLES = 1,
    parameter int CNT_W      = 8
) (
    input  logic              Clk,
    input  logic              RESET,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [IR_W-1:0]   prog_data,
    input  logic [AW:0]       prog_len,
    input  logic              start,
    input  logic              hold,
    input  logic              abort,
    output logic [IR_W-1:0]   IR_In,
    output logic              IR_Enable,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     idx,
    output logic [CNT_W-1:0]  issued
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0]    GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [AW:0]      DEPTH_L  = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, LOAD, GAP, DONE} state_t;

    state_t             state_r, state_s;
    logic [AW-1:0]      idx_r, idx_s;
    logic [GW-1:0]      gap_cnt_r, gap_cnt_s;
    logic [AW:0]        len_r, len_s;
    logic [AW:0]        len_eff_s;
    logic [AW:0]        last_s;
    logic               advance_s;
    logic               addr_ok_s;
    logic               wr_ok_s;
    logic [IR_W-1:0]    rd_data_s;
    logic [IR_W-1:0]    ir_in_r, ir_in_s;
    logic               ir_en_r, busy_r, done_r;
    logic [CNT_W-1:0]   issued_r;
    logic [IR_W-1:0]    mem_r [DEPTH];

    // Addresses beyond the buffer are only possible when DEPTH < 2**AW.
    generate
        if (DEPTH < (1 << AW)) begin : g_addr_chk
            assign addr_ok_s = ({1'b0, prog_addr} < DEPTH_L);
        end else begin : g_addr_all
            assign addr_ok_s = 1'b1;
        end
    endgenerate

    // Program writes are accepted only while not playing.
    assign wr_ok_s   = prog_we && addr_ok_s && ((state_r == IDLE) || (state_r == DONE));
    assign len_eff_s = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    assign last_s    = len_r - (AW+1)'(1);

    // Program buffer storage; deliberately not cleared by RESET.
    always_ff @(posedge Clk) begin
        if (wr_ok_s) begin
            mem_r[prog_addr] <= prog_data;
        end else begin
            mem_r[prog_addr] <= mem_r[prog_addr];
        end
    end

    // Next-state, gap counter, index and IR word selection.
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        gap_cnt_s = gap_cnt_r;
        len_s     = len_r;
        advance_s = 1'b0;
        rd_data_s = '0;
        ir_in_s   = ir_in_r;

        case (state_r)
            IDLE, DONE: begin
                if (start && (len_eff_s != '0)) begin
                    state_s = LOAD;
                    idx_s   = '0;
                    len_s   = len_eff_s;
                end else begin
                    state_s = state_r;
                end
            end
            LOAD: begin
                if (GAP_CYCLES > 0) begin
                    state_s   = GAP;
                    gap_cnt_s = '0;
                end else begin
                    advance_s = 1'b1;
                end
            end
            GAP: begin
                if (hold) begin
                    gap_cnt_s = gap_cnt_r;
                end else if (gap_cnt_r == GAP_LAST) begin
                    advance_s = 1'b1;
                end else begin
                    gap_cnt_s = gap_cnt_r + GW'(1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        if (advance_s) begin
            if ({1'b0, idx_r} != last_s) begin
                idx_s   = idx_r + AW'(1);
                state_s = LOAD;
            end else begin
`ifdef SEQ_LOOP_EN
                if (start) begin
                    idx_s   = '0;
                    state_s = LOAD;
                end else begin
                    state_s = DONE;
                end
`else
                state_s = DONE;
`endif
            end
        end else begin
            idx_s = idx_s;
        end

        if (abort) begin
            state_s = IDLE;
        end else begin
            state_s = state_s;
        end

        // A write landing in the same cycle as the read is forwarded.
        if (wr_ok_s && (prog_addr == idx_s)) begin
            rd_data_s = prog_data;
        end else begin
            rd_data_s = mem_r[idx_s];
        end

        if (state_s == LOAD) begin
            ir_in_s = rd_data_s;
        end else begin
            ir_in_s = ir_in_r;
        end
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge Clk) begin
        if (RESET) begin
            state_r   <= IDLE;
            idx_r     <= '0;
            gap_cnt_r <= '0;
            len_r     <= '0;
            ir_in_r   <= '0;
            ir_en_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            issued_r  <= '0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            gap_cnt_r <= gap_cnt_s;
            len_r     <= len_s;
            ir_in_r   <= ir_in_s;
            ir_en_r   <= (state_s == LOAD);
            busy_r    <= (state_s == LOAD) || (state_s == GAP);
            done_r    <= (state_s == DONE);
            if ((state_s == LOAD) && (issued_r != CNT_MAX)) begin
                issued_r <= issued_r + CNT_W'(1);
            end else begin
                issued_r <= issued_r;
            end
        end
    end

    assign IR_In     = ir_in_r;
    assign IR_Enable = ir_en_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign idx       = idx_r;
    assign issued    = issued_r;

endmodule
